hsi_stage_sequencer: RTL and testbench

//   Top-level controller for the hyperspectral kernel datapath. Starts the loop
//   sub-blocks in fixed order: 0 = band load, 1 = pixel load, 2 = result stream-out.

---
 rtl/hsi_ctrl_pkg.sv | 21 ++
 rtl/hsi_stall_watchdog.sv | 41 ++++
 rtl/hsi_stage_sequencer.sv | 155 +++++++++++++++
 tb/tb_hsi_stage_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hsi_ctrl_pkg
// Brief    : Shared sequencer state encoding and default sizing constants.
// Revision : 1.0 - initial release
// ============================================================================
package hsi_ctrl_pkg;

    localparam int C_NUM_STAGES = 3;
    localparam int C_CNT_W      = 16;
    localparam int C_IDX_W      = 2;
    localparam int C_STATE_W    = 2;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/hsi_stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : hsi_stall_watchdog
// Brief    : Counts consecutive stream-stall cycles and flags the threshold hit.
// Revision : 1.0 - initial release
// ============================================================================
module hsi_stall_watchdog
    import hsi_ctrl_pkg::*;
#(
    parameter int CNT_W = C_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             blk_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!en || blk_n || clr) begin
            r_count <= '0;
        end else if (r_count != c_cnt_max) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Compare one bit wider so a saturated count can never alias a small limit.
    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    assign hit         = en & ~blk_n & (limit != '0) & (w_count_inc == {1'b0, limit});

endmodule
`default_nettype wire

// File: rtl/hsi_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hsi_stage_sequencer
// Brief    : Block-level ap_ctrl sequencer launching kernel stages in order,
//            with an in-line stream stall watchdog per running stage.
// Revision : 1.0 - initial release
// ============================================================================
module hsi_stage_sequencer
    import hsi_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = C_NUM_STAGES,
    parameter int CNT_W      = C_CNT_W,
    parameter int IDX_W      = C_IDX_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic                  abort,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [NUM_STAGES-1:0] stage_blk_n,
    input  logic [CNT_W-1:0]      wdog_limit,
    output logic [IDX_W-1:0]      cur_stage,
    output logic                  stall_flag,
    output logic [IDX_W-1:0]      stall_stage
);

    localparam logic [IDX_W-1:0]      c_last_stage  = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0]      c_idx_one     = IDX_W'(1);
    localparam logic [NUM_STAGES-1:0] c_first_start = NUM_STAGES'(1);

    seq_state_t            r_state;
    seq_state_t            w_next_state;

    logic                  r_ready;
    logic [NUM_STAGES-1:0] r_stage_start;
    logic [IDX_W-1:0]      r_cur_stage;
    logic                  r_stall_flag;
    logic [IDX_W-1:0]      r_stall_stage;

    logic [NUM_STAGES-1:0] w_is_cur;
    logic                  w_cur_done_raw;
    logic                  w_cur_blk_n;
    logic                  w_in_run;
    logic                  w_accept;
    logic                  w_cur_done;
    logic                  w_abort_run;
    logic                  w_last;
    logic                  w_wdog_hit;
    logic                  w_stall_set;

    // Decode the running stage so done/blk_n from other stages never leak in.
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage_sel
        assign w_is_cur[g] = (r_cur_stage == IDX_W'(g));
    end

    assign w_cur_done_raw = |(stage_done & w_is_cur);
    assign w_cur_blk_n    = |(stage_blk_n & w_is_cur);
    assign w_in_run       = (r_state == ST_RUN);
    assign w_accept       = (r_state == ST_IDLE) & ap_start;
    assign w_cur_done     = w_in_run & w_cur_done_raw;
    assign w_abort_run    = w_in_run & abort;
    assign w_last         = (r_cur_stage == c_last_stage);
    assign w_stall_set    = w_wdog_hit & ~w_cur_done;

    hsi_stall_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .en    (w_in_run),
        .blk_n (w_cur_blk_n),
        .clr   (w_cur_done),
        .limit (wdog_limit),
        .hit   (w_wdog_hit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_cur_done_raw && w_last) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ap_idle     = (r_state == ST_IDLE);
        ap_done     = (r_state == ST_FINISH);
        ap_ready    = r_ready;
        stage_start = r_stage_start;
        cur_stage   = r_cur_stage;
        stall_flag  = r_stall_flag;
        stall_stage = r_stall_stage;
    end

    // Shifting the one-hot start gives the zero-bubble handoff; the last stage
    // simply shifts out, leaving all starts low for the FINISH cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ready       <= 1'b0;
            r_stage_start <= '0;
            r_cur_stage   <= '0;
            r_stall_flag  <= 1'b0;
            r_stall_stage <= '0;
        end else begin
            r_ready <= w_accept;
            if (w_accept) begin
                r_stage_start <= c_first_start;
                r_cur_stage   <= '0;
                r_stall_flag  <= 1'b0;
                r_stall_stage <= '0;
            end else if (w_abort_run) begin
                r_stage_start <= '0;
                r_cur_stage   <= '0;
            end else if (w_cur_done) begin
                r_stage_start <= r_stage_start << 1;
                r_cur_stage   <= w_last ? '0 : (r_cur_stage + c_idx_one);
            end
            // First hit of a run is the one reported; later hits keep it.
            if (w_stall_set && !r_stall_flag) begin
                r_stall_flag  <= 1'b1;
                r_stall_stage <= r_cur_stage;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hsi_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsi_stage_sequencer
// Brief    : Scoreboard bench: per-run event timeline predicted from stage
//            durations and stall patterns, compared by an output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hsi_stage_sequencer;
    import hsi_ctrl_pkg::*;

    localparam int N    = C_NUM_STAGES;
    localparam int CW   = C_CNT_W;
    localparam int IW   = C_IDX_W;
    localparam int MAXD = 1200;

    localparam int K_READY = 0;
    localparam int K_DONE  = 1;
    localparam int K_STAGE = 2;
    localparam int K_IDLE  = 3;
    localparam int K_STALL = 4;

    typedef struct {
        int cyc;
        int val;
    } evt_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  stage_done = '0;
    logic [N-1:0]  stage_blk_n = '1;
    logic [CW-1:0] wdog_limit = '0;
    logic          ap_ready, ap_done, ap_idle, stall_flag;
    logic [N-1:0]  stage_start;
    logic [IW-1:0] cur_stage, stall_stage;

    hsi_stage_sequencer #(.NUM_STAGES(N), .CNT_W(CW), .IDX_W(IW)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .abort       (abort),
        .stage_start (stage_start),
        .stage_done  (stage_done),
        .stage_blk_n (stage_blk_n),
        .wdog_limit  (wdog_limit),
        .cur_stage   (cur_stage),
        .stall_flag  (stall_flag),
        .stall_stage (stall_stage)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    evt_t  q_evt [5][$];
    string kname [5] = '{"ap_ready", "ap_done", "stage_start", "ap_idle", "stall"};

    int dur [N];
    bit low_pat [N][MAXD];
    int m_flag = 0;

    task automatic push(input int k, input int c, input int v);
        evt_t e;
        e.cyc = c;
        e.val = v;
        q_evt[k].push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic take(input int k, input int v);
        evt_t e;
        checks++;
        if (q_evt[k].size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected value %0d at cycle %0d, none required", kname[k], v, cyc);
        end else begin
            e = q_evt[k].pop_front();
            if (e.cyc != cyc || e.val != v) begin
                errors++;
                $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                         kname[k], v, cyc, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: any change on an observed output must match the next predicted event.
    int prev_stage = 0;
    int prev_idle  = 1;
    int prev_stall = 0;
    always @(negedge ap_clk) begin : p_monitor
        int v_stage;
        int v_stall;
        if (mon_en) begin
            v_stage = (int'(cur_stage) << N) | int'(stage_start);
            v_stall = (int'(stall_flag) << IW) | int'(stall_stage);
            if (ap_ready) take(K_READY, 1);
            if (ap_done) take(K_DONE, 1);
            if (v_stage != prev_stage) take(K_STAGE, v_stage);
            if (int'(ap_idle) != prev_idle) take(K_IDLE, int'(ap_idle));
            if (v_stall != prev_stall) take(K_STALL, v_stall);
            prev_stage = v_stage;
            prev_idle  = int'(ap_idle);
            prev_stall = v_stall;
        end
    end

    task automatic next_cycle();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic noise(input int k);
        stage_done  = N'($urandom);
        stage_blk_n = N'($urandom);
        if (k >= 0) stage_done[k] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ap_start = 1'b0;
            noise(-1);
            abort = ($urandom_range(0, 3) == 0);
            next_cycle();
        end
        abort = 1'b0;
    endtask

    task automatic clear_pat();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < MAXD; j++)
                low_pat[k][j] = 1'b0;
    endtask

    // One kernel run launched in the current (idle) cycle. Stage k keeps its start
    // high for dur[k] cycles; low_pat marks cycles where that stage's blk_n is 0.
    // Optional abort or reset at (stage, offset); keep holds ap_start for relaunch.
    task automatic do_run(input int ab_k, input int ab_j, input int rst_k, input int rst_j,
                          input int limit, input bit keep);
        int s;
        int b;
        s = cyc;
        push(K_READY, s + 1, 1);
        push(K_IDLE, s + 1, 0);
        push(K_STAGE, s + 1, 1);
        if (m_flag != 0) push(K_STALL, s + 1, 0);
        m_flag = 0;
        b = s + 1;
        for (int k = 0; k < N; k++) begin
            int jlim;
            int run;
            int fin;
            fin  = 0;
            jlim = dur[k] - 1;
            if (k == ab_k) begin
                fin = 1;
                jlim = ab_j;
                low_pat[k][ab_j] = 1'b0;
            end
            if (k == rst_k) begin
                fin = 2;
                jlim = rst_j - 1;
            end
            run = 0;
            for (int j = 0; j < jlim; j++) begin
                run = low_pat[k][j] ? run + 1 : 0;
                if (limit != 0 && run == limit && m_flag == 0) begin
                    m_flag = 1;
                    push(K_STALL, b + j + 1, (1 << IW) + k);
                end
            end
            if (fin == 1) begin
                push(K_STAGE, b + ab_j + 1, 0);
                push(K_IDLE, b + ab_j + 1, 1);
                break;
            end
            if (fin == 2) begin
                push(K_STAGE, b + rst_j, 0);
                push(K_IDLE, b + rst_j, 1);
                if (m_flag != 0) push(K_STALL, b + rst_j, 0);
                m_flag = 0;
                break;
            end
            if (k < N - 1) begin
                push(K_STAGE, b + dur[k], ((k + 1) << N) + (1 << (k + 1)));
            end else begin
                push(K_STAGE, b + dur[k], 0);
                push(K_DONE, b + dur[k], 1);
                push(K_IDLE, b + dur[k] + 1, 1);
            end
            b += dur[k];
        end

        ap_start   = 1'b1;
        wdog_limit = CW'(limit);
        noise(-1);
        abort = ($urandom_range(0, 3) == 0);
        next_cycle();
        ap_start = keep;
        abort    = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < dur[k]; j++) begin
                noise(k);
                stage_blk_n[k] = !low_pat[k][j];
                if (j == dur[k] - 1) stage_done[k] = 1'b1;
                if (k == rst_k && j == rst_j) begin
                    stage_done[k] = 1'b0;
                    #2;
                    ap_rst_n = 1'b0;
                    #1;
                    chk("rst_mid_stage_start", int'(stage_start), 0);
                    chk("rst_mid_idle", int'(ap_idle), 1);
                    chk("rst_mid_cur_stage", int'(cur_stage), 0);
                    chk("rst_mid_stall_flag", int'(stall_flag), 0);
                    next_cycle();
                    ap_rst_n = 1'b1;
                    ap_start = 1'b0;
                    return;
                end
                if (k == ab_k && j == ab_j) begin
                    abort = 1'b1;
                    stage_blk_n[k] = 1'b1;
                    next_cycle();
                    abort    = 1'b0;
                    ap_start = 1'b0;
                    return;
                end
                next_cycle();
            end
        end
        noise(-1);
        next_cycle();
    endtask

    initial begin : p_timeout
        #500000;
        $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : p_stim
        repeat (3) @(posedge ap_clk);
        #1;
        chk("reset_ap_idle", int'(ap_idle), 1);
        chk("reset_ap_ready", int'(ap_ready), 0);
        chk("reset_ap_done", int'(ap_done), 0);
        chk("reset_stage_start", int'(stage_start), 0);
        chk("reset_cur_stage", int'(cur_stage), 0);
        chk("reset_stall_flag", int'(stall_flag), 0);
        chk("reset_stall_stage", int'(stall_stage), 0);
        ap_rst_n = 1'b1;
        mon_en   = 1'b1;
        while (cyc < 10) next_cycle();

        // Launch at cycle 10, dones at 20/35/50.
        dur = '{10, 15, 15};
        clear_pat();
        do_run(-1, -1, -1, -1, 0, 1'b0);
        chk("t1_idle_after_run", int'(ap_idle), 1);
        idle_cycles(3);

        // Eight consecutive stalled cycles in stage 1 with limit 8.
        dur = '{5, 15, 5};
        clear_pat();
        for (int j = 2; j < 10; j++) low_pat[1][j] = 1'b1;
        do_run(-1, -1, -1, -1, 8, 1'b0);
        idle_cycles(2);

        // 7 low, 1 high, 7 low: below threshold; also clears the earlier flag.
        dur = '{4, 20, 4};
        clear_pat();
        for (int j = 1; j < 8; j++) low_pat[1][j] = 1'b1;
        for (int j = 9; j < 16; j++) low_pat[1][j] = 1'b1;
        do_run(-1, -1, -1, -1, 8, 1'b0);
        idle_cycles(1);

        // Watchdog disabled across a long stall.
        dur = '{1002, 3, 3};
        clear_pat();
        for (int j = 0; j < 1002; j++) low_pat[0][j] = 1'b1;
        do_run(-1, -1, -1, -1, 0, 1'b0);
        idle_cycles(2);

        // Threshold reached in the same cycle as stage_done: done wins.
        dur = '{3, 3, 8};
        clear_pat();
        for (int j = 0; j < 8; j++) low_pat[2][j] = 1'b1;
        do_run(-1, -1, -1, -1, 8, 1'b0);
        idle_cycles(2);

        // Stall in stage 0, then abort coinciding with stage_done[0]; flag retained.
        dur = '{6, 4, 4};
        clear_pat();
        for (int j = 0; j < 3; j++) low_pat[0][j] = 1'b1;
        do_run(0, 5, -1, -1, 2, 1'b0);
        chk("t4_idle_after_abort", int'(ap_idle), 1);
        chk("t4_flag_retained", int'(stall_flag), 1);
        idle_cycles(2);

        // Reset asserted mid-stage 1 after a stall was flagged.
        dur = '{6, 10, 6};
        clear_pat();
        for (int j = 0; j < 4; j++) low_pat[0][j] = 1'b1;
        do_run(-1, -1, 1, 3, 3, 1'b0);
        idle_cycles(2);

        // ap_start held high across two runs.
        dur = '{2, 3, 1};
        clear_pat();
        do_run(-1, -1, -1, -1, 0, 1'b1);
        dur = '{1, 1, 1};
        do_run(-1, -1, -1, -1, 0, 1'b0);
        idle_cycles(2);

        for (int it = 0; it < 40; it++) begin
            int ak;
            int aj;
            int lim;
            bit kp;
            for (int k = 0; k < N; k++) dur[k] = $urandom_range(1, 12);
            clear_pat();
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < dur[k]; j++) low_pat[k][j] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 1) begin
                    int st;
                    int ln;
                    st = $urandom_range(0, dur[k] - 1);
                    ln = $urandom_range(2, 10);
                    for (int j = st; j < st + ln && j < dur[k]; j++) low_pat[k][j] = 1'b1;
                end
            end
            lim = $urandom_range(0, 6);
            ak  = -1;
            aj  = -1;
            if ($urandom_range(0, 4) == 0) begin
                ak = $urandom_range(0, N - 1);
                aj = $urandom_range(0, dur[ak] - 1);
            end
            kp = (ak < 0) && ($urandom_range(0, 2) == 0);
            do_run(ak, aj, -1, -1, lim, kp);
            if (!kp) idle_cycles($urandom_range(0, 3));
        end

        idle_cycles(4);
        mon_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            while (q_evt[k].size() > 0) begin
                evt_t e;
                e = q_evt[k].pop_front();
                checks++;
                errors++;
                $display("FAIL %s: required %0d at cycle %0d, never observed", kname[k], e.val, e.cyc);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
